ls_unit_pipe: RTL and testbench

- Parametrised, buffered successor to the single-shot load/store functional unit.
- Accepts issued load/store ops into an in-order request FIFO and computes the effective address.
- Drives a hit/miss data-memory port, retrying until hit, and applies byte/half/word lane selection with sign or zero extension.
- Returns results to CDB/ROB through a valid/ready writeback handshake; sits between the RS issue stage and the CDB arbiter.

---
 rtl/ls_unit_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_ls_unit_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_unit_pipe.sv
// Buffered load/store unit: in-order request FIFO, hit/miss memory port, CDB writeback.
// Optional misalignment trap enabled by defining LS_UNIT_MISALIGN_CHK_EN.
module ls_unit_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_load,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [2:0]       in_func3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mem_read,
    output logic             mem_write,
    output logic [XLEN-1:0]  mem_addr,
    output logic [1:0]       mem_size,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_hit,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [XLEN-1:0]  wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_is_store
`ifdef LS_UNIT_MISALIGN_CHK_EN
    ,
    output logic             wb_exc
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t state, state_n;

    logic             q_ld   [DEPTH];
    logic [XLEN-1:0]  q_ea   [DEPTH];
    logic [XLEN-1:0]  q_src2 [DEPTH];
    logic [2:0]       q_f3   [DEPTH];
    logic [TAG_W-1:0] q_tag  [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, enq, pop;

    logic             h_ld;
    logic [XLEN-1:0]  h_ea, h_src2;
    logic [2:0]       h_f3;
    logic [TAG_W-1:0] h_tag;
    logic [1:0]       lane;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [XLEN-1:0]  ld_val, st_data, cap_data;
    logic             cap_en, cap_exc, head_mis;

    logic [XLEN-1:0]  wb_data_q;
    logic [TAG_W-1:0] wb_tag_q;
    logic             wb_st_q, exc_q;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full && !flush;
    assign enq      = in_valid && in_ready;

    assign h_ld   = q_ld[rd_ptr];
    assign h_ea   = q_ea[rd_ptr];
    assign h_src2 = q_src2[rd_ptr];
    assign h_f3   = q_f3[rd_ptr];
    assign h_tag  = q_tag[rd_ptr];
    assign lane   = h_ea[1:0];

`ifdef LS_UNIT_MISALIGN_CHK_EN
    assign head_mis = !empty &&
                      (((h_f3[1:0] == 2'b01) && h_ea[0]) ||
                       ((h_f3[1:0] == 2'b10) && (lane != 2'b00)));
    assign wb_exc   = wb_valid && exc_q;
`else
    assign head_mis = 1'b0;
`endif

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (enq) begin
            q_ld[wr_ptr]   <= in_is_load;
            q_ea[wr_ptr]   <= in_src1 + in_imm;
            q_src2[wr_ptr] <= in_src2;
            q_f3[wr_ptr]   <= in_func3;
            q_tag[wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        byte_v = 8'(mem_rdata >> {lane, 3'b000});
        half_v = 16'(mem_rdata >> {h_ea[1], 4'b0000});
        ld_val = '0;
        case (h_f3)
            3'b000:  ld_val = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b001:  ld_val = {{(XLEN-16){half_v[15]}}, half_v};
            3'b010:  ld_val = mem_rdata;
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, byte_v};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, half_v};
            default: ld_val = '0;
        endcase
        st_data  = (h_f3[1:0] == 2'b10) ? h_src2 : (h_src2 << {lane, 3'b000});
        cap_data = (cap_exc || !h_ld) ? '0 : ld_val;
    end

    always_comb begin
        state_n   = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wb_valid  = 1'b0;
        pop       = 1'b0;
        cap_en    = 1'b0;
        cap_exc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_mis) begin
                        cap_en  = 1'b1;
                        cap_exc = 1'b1;
                        state_n = RESP;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (head_mis) begin
                    cap_en  = 1'b1;
                    cap_exc = 1'b1;
                    state_n = RESP;
                end else begin
                    mem_read  = h_ld;
                    mem_write = !h_ld;
                    if (mem_hit) begin
                        cap_en  = 1'b1;
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    pop     = 1'b1;
                    state_n = (count > CW'(1)) ? REQ : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Squash wins over every request, result and transition.
        if (flush) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            wb_valid  = 1'b0;
            pop       = 1'b0;
            cap_en    = 1'b0;
            state_n   = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wb_data_q <= '0;
            wb_tag_q  <= '0;
            wb_st_q   <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (cap_en) begin
                wb_data_q <= cap_data;
                wb_tag_q  <= h_tag;
                wb_st_q   <= !h_ld;
                exc_q     <= cap_exc;
            end
        end
    end

    assign mem_addr    = (mem_read || mem_write) ? {h_ea[XLEN-1:2], 2'b00} : '0;
    assign mem_size    = (mem_read || mem_write) ? h_f3[1:0] : 2'b00;
    assign mem_wdata   = mem_write ? st_data : '0;
    assign wb_data     = wb_data_q;
    assign wb_tag      = wb_tag_q;
    assign wb_is_store = wb_st_q;

endmodule

// File: tb/tb_ls_unit_pipe.sv
// Directed and randomized checks of ls_unit_pipe against a queue-based reference model.
module tb_ls_unit_pipe;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_is_load;
    logic [31:0] in_src1, in_src2, in_imm;
    logic [2:0]  in_func3;
    logic [4:0]  in_tag;
    logic        mem_read, mem_write, mem_hit;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        wb_valid, wb_ready, wb_is_store;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
`ifdef LS_UNIT_MISALIGN_CHK_EN
    logic        wb_exc;
`endif

    ls_unit_pipe #(.XLEN(32), .TAG_W(5), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
        .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
        .in_func3(in_func3), .in_tag(in_tag),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_hit(mem_hit),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_is_store(wb_is_store)
`ifdef LS_UNIT_MISALIGN_CHK_EN
        , .wb_exc(wb_exc)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic [31:0] ea;
        logic [31:0] src2;
        logic [2:0]  f3;
        logic [4:0]  tag;
    } op_t;

    op_t         q[$];
    logic [31:0] pend;
    int          stall = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] im, input logic [2:0] f3, input logic [4:0] tg);
        in_is_load = ld;
        in_src1    = s1;
        in_src2    = s2;
        in_imm     = im;
        in_func3   = f3;
        in_tag     = tg;
    endtask

    // Result expected on the CDB for a load, from plain shift/mask arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] ea,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * ea[1:0])) & 32'hFF;
        h = (rd >> (16 * ea[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2:    return rd;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] ea,
                                              input logic [31:0] s2);
        if (f3 == 3'd2) return s2;
        return s2 << (8 * ea[1:0]);
    endfunction

    task automatic rcycle(input bit allow_in);
        logic [31:0] s1, im;
        logic [2:0]  f3;
        logic        ld;
        op_t         h, o;
        nx();
        ld = 1'($urandom);
        f3 = ld ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
        s1 = $urandom & ~32'h3;
        im = $urandom;
        if (f3[1:0] == 2'b01) im = im & ~32'h1;
        if (f3[1:0] == 2'b10) im = im & ~32'h3;
        set_op(ld, s1, $urandom, im, f3, 5'($urandom));
        in_valid  = allow_in && 1'($urandom);
        mem_hit   = ($urandom_range(0, 2) != 0);
        wb_ready  = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        chk("rnd_in_ready", in_ready, (q.size() < DEPTH));
        chk("rnd_req_nonempty", (mem_read || mem_write) && (q.size() == 0), 0);
        if ((mem_read || mem_write) && q.size() > 0) begin
            h = q[0];
            chk("rnd_req_kind", mem_read, h.ld);
            chk("rnd_addr", mem_addr, h.ea & ~32'h3);
            chk("rnd_size", mem_size, h.f3[1:0]);
            chk("rnd_req_wb_excl", wb_valid, 0);
            if (!h.ld) chk("rnd_wdata", mem_wdata, ref_wdata(h.f3, h.ea, h.src2));
            if (mem_hit) pend = h.ld ? ref_load(h.f3, h.ea, mem_rdata) : 32'd0;
        end
        if (wb_valid && q.size() > 0) begin
            h = q[0];
            chk("rnd_wb_tag", wb_tag, h.tag);
            chk("rnd_wb_data", wb_data, pend);
            chk("rnd_wb_store", wb_is_store, !h.ld);
            if (wb_ready) begin
                void'(q.pop_front());
                stall = 0;
            end
        end
        if (in_valid && in_ready) begin
            o.ld = ld; o.ea = s1 + im; o.src2 = in_src2; o.f3 = f3; o.tag = in_tag;
            q.push_back(o);
        end
        if (q.size() > 0) stall++;
        if (stall > 60) begin
            chk("rnd_progress", stall, 0);
            stall = 0;
        end
    endtask

    initial begin
        int rd_cnt, got;
        bit first;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        set_op(1'b0, 0, 0, 0, 3'd0, 5'd0);
        mem_hit = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_tag", wb_tag, 0);
        nx(); reset = 1'b0; #1;
        chk("post_rst_in_ready", in_ready, 1);

        // LB, immediate hit
        nx(); set_op(1'b1, 32'h100, 0, 32'd3, 3'd0, 5'd7);
        in_valid = 1'b1; mem_hit = 1'b1; mem_rdata = 32'h80FF_0000; #1;
        chk("lb_in_ready", in_ready, 1);
        nx(); in_valid = 1'b0; #1;
        chk("lb_idle_no_req", mem_read, 0);
        nx(); #1;
        chk("lb_req", mem_read, 1);
        chk("lb_addr", mem_addr, 32'h100);
        chk("lb_size", mem_size, 0);
        nx(); #1;
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_tag", wb_tag, 7);
        chk("lb_wb_store", wb_is_store, 0);
        chk("lb_no_req_resp", mem_read, 0);
        wb_ready = 1'b1;
        nx(); wb_ready = 1'b0; #1;
        chk("lb_popped", wb_valid, 0);

        // LHU with three misses
        nx(); set_op(1'b1, 32'h200, 0, 32'd2, 3'd5, 5'd9);
        in_valid = 1'b1; mem_hit = 1'b0; #1;
        nx(); in_valid = 1'b0; #1;
        rd_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            nx(); #1;
            if (mem_read) rd_cnt++;
        end
        nx(); mem_hit = 1'b1; mem_rdata = 32'hBEEF_1234; #1;
        if (mem_read) rd_cnt++;
        chk("lhu_addr", mem_addr, 32'h200);
        nx(); mem_hit = 1'b0; #1;
        chk("lhu_read_cycles", rd_cnt, 4);
        chk("lhu_wb_valid", wb_valid, 1);
        chk("lhu_wb_data", wb_data, 32'h0000_BEEF);
        chk("lhu_wb_tag", wb_tag, 9);
        wb_ready = 1'b1;
        nx(); wb_ready = 1'b0;

        // SB into lane 1
        set_op(1'b0, 32'h300, 32'hAB, 32'd1, 3'd0, 5'd3);
        in_valid = 1'b1; #1;
        nx(); in_valid = 1'b0; #1;
        nx(); mem_hit = 1'b1; #1;
        chk("sb_write", mem_write, 1);
        chk("sb_read", mem_read, 0);
        chk("sb_wdata", mem_wdata, 32'h0000_AB00);
        chk("sb_size", mem_size, 0);
        chk("sb_addr", mem_addr, 32'h300);
        nx(); mem_hit = 1'b0; #1;
        chk("sb_wb_valid", wb_valid, 1);
        chk("sb_wb_store", wb_is_store, 1);
        chk("sb_wb_data", wb_data, 0);
        wb_ready = 1'b1;
        nx(); wb_ready = 1'b0;

        // Fill to DEPTH, then drain in order
        mem_hit = 1'b1; mem_rdata = 32'h1122_3344;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) nx();
            set_op(1'b1, 32'h400 + 32'(16 * i), 0, 0, 3'd2, 5'(10 + i));
            in_valid = 1'b1; #1;
            chk("fill_in_ready_pre", in_ready, 1);
        end
        nx(); in_valid = 1'b0; #1;
        chk("fill_full", in_ready, 0);
        wb_ready = 1'b1; got = 0; first = 1'b0;
        for (int c = 0; c < 40 && got < DEPTH; c++) begin
            if (c > 0) nx();
            #1;
            if (first) begin
                chk("fill_in_ready_after_pop", in_ready, 1);
                first = 1'b0;
            end
            if (wb_valid) begin
                chk("fill_wb_tag", wb_tag, 32'(10 + got));
                chk("fill_wb_data", wb_data, 32'h1122_3344);
                got++;
                if (got == 1) first = 1'b1;
            end
        end
        chk("fill_results", got, DEPTH);
        nx(); wb_ready = 1'b0; mem_hit = 1'b0;

        // Flush while a store is requesting
        for (int i = 0; i < 3; i++) begin
            set_op(1'b0, 32'h500, 32'h55, 32'(4 * i), 3'd2, 5'(20 + i));
            in_valid = 1'b1;
            nx();
        end
        in_valid = 1'b0; #1;
        for (int c = 0; c < 10 && !mem_write; c++) begin
            nx(); #1;
        end
        chk("flush_in_req", mem_write, 1);
        flush = 1'b1; mem_hit = 1'b1; in_valid = 1'b1;
        set_op(1'b1, 32'h600, 0, 0, 3'd2, 5'd30); #1;
        chk("flush_no_write", mem_write, 0);
        chk("flush_no_read", mem_read, 0);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_wb_valid", wb_valid, 0);
        nx(); flush = 1'b0; in_valid = 1'b0; #1;
        chk("flush_after_in_ready", in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            chk("flush_after_wb", wb_valid, 0);
            chk("flush_after_req", mem_read || mem_write, 0);
            nx(); #1;
        end
        mem_hit = 1'b0;

        // Asynchronous reset mid-request
        set_op(1'b1, 32'h700, 0, 0, 3'd2, 5'd1);
        in_valid = 1'b1;
        nx(); in_valid = 1'b0;
        nx(); #1;
        chk("ar_req", mem_read, 1);
        #2 reset = 1'b1; #1;
        chk("ar_read_cleared", mem_read, 0);
        chk("ar_in_ready", in_ready, 1);
        nx(); reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nx(); #1;
            chk("ar_no_wb", wb_valid, 0);
            chk("ar_no_req", mem_read, 0);
        end

        // Randomized traffic against the queue model
        pend = '0;
        for (int i = 0; i < 400; i++) rcycle(1'b1);
        for (int i = 0; i < 80 && q.size() > 0; i++) rcycle(1'b0);
        chk("rnd_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
